i2s_transmitter: RTL and testbench

Drives an I2S DAC/codec from the autotune output path. It generates its own sclk and ws and serializes one 16-bit sample per frame, MSB first. Each sample goes to both the left and the right slot. Framing, bit timing and reset phase are identical to the I2S receiver, so a tx→rx loopback recovers samples bit-exactly. Samples enter through a valid/ready handshake into a one-entry holding buffer.

---
 rtl/i2s_transmitter.sv | 118 +++++++++++
 tb/tb_i2s_transmitter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_transmitter.sv
// I2S transmitter: generates sclk/ws and serialises one DATA_WIDTH-bit sample
// per frame, MSB first, into both slots. Samples arrive through a one-entry buffer.
`timescale 1ns/1ps

module i2s_transmitter #(
  parameter int SCLK_PERIOD = 36,
  parameter int I2S_PERIOD  = 64,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid_in,
  output logic                  data_ready_out,
  output logic                  sclk_out,
  output logic                  ws_out,
  output logic                  sdata_out,
  output logic                  frame_start_out,
  output logic                  underrun_out
);

  localparam int SC_W  = $clog2(SCLK_PERIOD);
  localparam int CYC_W = $clog2(I2S_PERIOD);

  localparam logic [SC_W-1:0]  SC_LAST   = SC_W'(SCLK_PERIOD - 1);
  localparam logic [SC_W-1:0]  SC_RISE   = SC_W'(SCLK_PERIOD / 2 - 1);
  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(I2S_PERIOD - 1);
  localparam logic [CYC_W-1:0] CYC_MID   = CYC_W'(I2S_PERIOD / 2 - 1);
  localparam logic [CYC_W-1:0] CYC_HALF  = CYC_W'(I2S_PERIOD / 2);
  localparam logic [CYC_W-1:0] LEFT_END  = CYC_W'(DATA_WIDTH);
  localparam logic [CYC_W-1:0] RIGHT_END = CYC_W'(I2S_PERIOD / 2 + DATA_WIDTH);

  logic [SC_W-1:0]       sclk_cycle;
  logic [CYC_W-1:0]      cycle;
  logic                  full;
  logic [DATA_WIDTH-1:0] buffer;
  logic [DATA_WIDTH-1:0] frame;
  logic [DATA_WIDTH-1:0] shift;

  logic                  fall;
  logic                  load;
  logic                  accept;
  logic                  in_data;
  logic [DATA_WIDTH-1:0] load_word;

  assign fall           = (sclk_cycle == SC_LAST);
  assign load           = fall && (cycle == CYC_LAST);
  assign data_ready_out = ~full;
  assign accept         = data_valid_in && ~full;
  assign load_word      = full ? buffer : '0;

  // The cycle being left decides what the cycle being entered carries; current
  // cycles 0..DW-1 and 32..31+DW feed data cycles 1..DW and 33..32+DW.
  assign in_data = (cycle < LEFT_END) || ((cycle >= CYC_HALF) && (cycle < RIGHT_END));

  // NOTE: every register below is state, so all updates use non-blocking
  // assignments; reads in this block see the pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sclk_cycle      <= SC_LAST;
      cycle           <= CYC_LAST;
      sclk_out        <= 1'b1;
      ws_out          <= 1'b0;
      sdata_out       <= 1'b0;
      full            <= 1'b0;
      frame           <= '0;
      shift           <= '0;
      frame_start_out <= 1'b0;
      underrun_out    <= 1'b0;
    end else begin
      frame_start_out <= 1'b0;
      underrun_out    <= 1'b0;

      if (fall) begin
        sclk_cycle <= '0;
        cycle      <= cycle + CYC_W'(1);
        sclk_out   <= 1'b0;
      end else begin
        sclk_cycle <= sclk_cycle + SC_W'(1);
        if (sclk_cycle == SC_RISE) sclk_out <= 1'b1;
      end

      if (fall) begin
        if (cycle == CYC_MID)       ws_out <= 1'b1;
        else if (cycle == CYC_LAST) ws_out <= 1'b0;

        if (in_data) begin
          sdata_out <= shift[DATA_WIDTH-1];
          shift     <= {shift[DATA_WIDTH-2:0], 1'b0};
        end else begin
          sdata_out <= 1'b0;
        end

        // Right slot replays the same frame word after the ws edge.
        if (cycle == CYC_MID) shift <= frame;

        if (load) begin
          frame           <= load_word;
          shift           <= load_word;
          frame_start_out <= 1'b1;
          underrun_out    <= ~full;
        end
      end

      // An accept can only happen with full low, so a same-edge load has
      // already underrun and the new sample waits for the next frame.
      if (accept)    full <= 1'b1;
      else if (load) full <= 1'b0;
    end
  end

  // NOTE: the sample buffer has no reset; the full flag alone says whether its
  // contents are meaningful.
  always_ff @(posedge clk_in) begin
    if (accept) buffer <= data_in;
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: cycle-accurate timing model plus a ws-relative
// serial decoder whose recovered words are scored against a queue of frames.
`timescale 1ns/1ps

module tb_i2s_transmitter;

  localparam int SP    = 36;
  localparam int DW    = 16;
  localparam int FRAME = SP * 64;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          data_valid_in = 1'b0;
  logic          data_ready_out;
  logic          sclk_out;
  logic          ws_out;
  logic          sdata_out;
  logic          frame_start_out;
  logic          underrun_out;

  always #5 clk_in = ~clk_in;

  i2s_transmitter #(.SCLK_PERIOD(SP), .I2S_PERIOD(64), .DATA_WIDTH(DW)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .data_in         (data_in),
    .data_valid_in   (data_valid_in),
    .data_ready_out  (data_ready_out),
    .sclk_out        (sclk_out),
    .ws_out          (ws_out),
    .sdata_out       (sdata_out),
    .frame_start_out (frame_start_out),
    .underrun_out    (underrun_out)
  );

  int errors = 0;
  int checks = 0;

  // Timing model state (values after the most recent edge).
  int            sc;
  int            cy;
  logic [DW-1:0] pend_q[$];   // samples accepted but not yet loaded
  logic [DW-1:0] out_q[$];    // frame words expected on the wire
  logic [DW-1:0] mframe;
  logic          e_sclk, e_ws, e_sdata, e_fs, e_ur, e_ready;
  logic          last_acc;

  // Serial decoder state.
  int            bitcnt;
  logic          prev_sclk, prev_ws, have_cur;
  logic [DW-1:0] dec_l, dec_r, cur_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_bit(input logic [DW-1:0] f, input int c);
    logic [DW-1:0] t;
    t = '0;
    if (c >= 1 && c <= DW)            t = f >> (DW - c);
    else if (c >= 33 && c <= 32 + DW) t = f >> (DW + 32 - c);
    return t[0];
  endfunction

  task automatic tick();
    logic          r;
    logic          was_full;
    logic [DW-1:0] f;
    @(posedge clk_in);
    r = rst_in;
    if (r) begin
      sc = SP - 1;
      cy = 63;
      pend_q.delete();
      out_q.delete();
      mframe  = '0;
      e_sclk  = 1'b1;
      e_ws    = 1'b0;
      e_sdata = 1'b0;
      e_fs    = 1'b0;
      e_ur    = 1'b0;
      last_acc = 1'b0;
    end else begin
      was_full = (pend_q.size() != 0);
      last_acc = data_valid_in && !was_full;
      e_fs = 1'b0;
      e_ur = 1'b0;
      if (sc == SP - 1) begin
        if (cy == 63) begin
          if (was_full) f = pend_q.pop_front();
          else          f = '0;
          mframe = f;
          out_q.push_back(f);
          e_fs = 1'b1;
          e_ur = !was_full;
        end
        sc = 0;
        cy = (cy + 1) % 64;
        e_sdata = model_bit(mframe, cy);
      end else begin
        sc++;
      end
      e_sclk = (sc >= SP / 2);
      e_ws   = (cy >= 32);
      if (last_acc) pend_q.push_back(data_in);
    end
    e_ready = (pend_q.size() == 0);

    @(negedge clk_in);
    chk("sclk",        sclk_out,        e_sclk);
    chk("ws",          ws_out,          e_ws);
    chk("sdata",       sdata_out,       e_sdata);
    chk("frame_start", frame_start_out, e_fs);
    chk("underrun",    underrun_out,    e_ur);
    chk("ready",       data_ready_out,  e_ready);

    if (r) begin
      bitcnt = 0; prev_sclk = 1'b1; prev_ws = 1'b0; have_cur = 1'b0;
      dec_l = '0; dec_r = '0;
    end else begin
      if (ws_out !== prev_ws) bitcnt = 0;
      if (prev_sclk === 1'b0 && sclk_out === 1'b1) begin
        bitcnt++;
        if (bitcnt >= 2 && bitcnt <= DW + 1) begin
          if (ws_out) dec_r = {dec_r[DW-2:0], sdata_out};
          else        dec_l = {dec_l[DW-2:0], sdata_out};
        end
      end
      if (e_fs) begin
        if (have_cur) begin
          chk("rx_left",  dec_l, cur_exp);
          chk("rx_right", dec_r, cur_exp);
        end
        cur_exp  = out_q.pop_front();
        have_cur = 1'b1;
        dec_l = '0;
        dec_r = '0;
      end
      prev_sclk = sclk_out;
      prev_ws   = ws_out;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [DW-1:0] d);
    int b;
    data_valid_in = 1'b1;
    data_in       = d;
    b = 0;
    do begin
      tick();
      b++;
    end while (!last_acc && b < 3 * FRAME);
    data_valid_in = 1'b0;
    chk("send_accepted", last_acc, 1'b1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] stream [4];
    int acc_in_frame;
    logic seen_load;
    int b;
    stream = '{16'h0001, 16'h8000, 16'hFFFF, 16'h1234};

    // Reset hold and release; first edge after release is an underrunning load.
    rst_in = 1'b1;
    run(4);
    rst_in = 1'b0;
    run(1);
    chk("first_load_underrun", underrun_out, 1'b1);

    // Single sample one clk after reset, then idle frames.
    send(16'hA5C3);
    run(3 * FRAME);

    // Loopback stream through the decoder.
    foreach (stream[i]) send(stream[i]);
    run(2 * FRAME);

    // Backpressure: valid held high, data increments per accept.
    data_valid_in = 1'b1;
    data_in       = 16'h0100;
    acc_in_frame  = 0;
    seen_load     = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      tick();
      if (e_fs) begin
        if (seen_load) chk("one_accept_per_frame", acc_in_frame, 1);
        acc_in_frame = 0;
        seen_load    = 1'b1;
      end
      if (last_acc) begin
        acc_in_frame++;
        data_in = data_in + 16'd1;
      end
    end
    data_valid_in = 1'b0;
    run(2 * FRAME);

    // Accept on the very edge that loads an empty buffer.
    b = 0;
    while (!(sc == SP - 1 && cy == 63) && b < 2 * FRAME) begin
      tick();
      b++;
    end
    chk("reach_load_edge", (sc == SP - 1 && cy == 63), 1'b1);
    data_valid_in = 1'b1;
    data_in       = 16'h5A5A;
    tick();
    data_valid_in = 1'b0;
    chk("simul_underrun", underrun_out, 1'b1);
    chk("simul_buffered", data_ready_out, 1'b0);
    run(2 * FRAME);

    // Mid-frame reset with a sample sitting in the buffer.
    send(16'h3C3C);
    b = 0;
    while (cy != 40 && b < 2 * FRAME) begin
      tick();
      b++;
    end
    chk("reach_cycle_40", cy, 40);
    chk("buffer_full_before_reset", data_ready_out, 1'b0);
    rst_in = 1'b1;
    run(2);
    chk("reset_ready", data_ready_out, 1'b1);
    chk("reset_sclk",  sclk_out,       1'b1);
    rst_in = 1'b0;
    run(3 * FRAME);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
